// File: rtl/c_rr_therm_mask.sv
// Multi-channel round-robin pointer tracker: one-hot pointer plus registered thermometer mask.
// Optional check mode via `define C_RR_THERM_MASK_CHECK_EN (flags multi-hot gnt / bad load_ptr).

module c_rr_therm_mask_chan #(
  parameter int width     = 8,
  parameter int reset_idx = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_update,
  input  logic [width-1:0] i_gnt,
  input  logic             i_load,
  input  logic [width-1:0] i_load_ptr,
  output logic [width-1:0] o_ptr,
  output logic [width-1:0] o_mask,
  output logic             o_err
);
  // Index 0 is the MSB, so the thermometer is an OR-scan from the top bit down.
  localparam logic [width-1:0] RST_PTR  = {1'b1, {(width-1){1'b0}}} >> reset_idx;
  localparam logic [width-1:0] RST_MASK = {width{1'b1}} >> reset_idx;

  function automatic logic [width-1:0] pfx_or(input logic [width-1:0] v);
    logic [width-1:0] r;
    r[width-1] = v[width-1];
    for (int p = width-2; p >= 0; p--) r[p] = r[p+1] | v[p];
    return r;
  endfunction

  logic [width-1:0] r_ptr, r_mask;
  logic [width-1:0] w_gnt_hi, w_gnt_first, w_adv, w_nxt_ptr;
  logic             w_nxt_err;

  // w_gnt_hi[p]: some grant bit sits at a lower index than p
  assign w_gnt_hi    = pfx_or(i_gnt) >> 1;
  assign w_gnt_first = i_gnt & ~w_gnt_hi;
  assign w_adv       = {w_gnt_first[0], w_gnt_first[width-1:1]};

`ifdef C_RR_THERM_MASK_CHECK_EN
  logic [width-1:0] w_ld_hi;
  logic             w_gnt_multi, w_ld_bad;
  assign w_ld_hi     = pfx_or(i_load_ptr) >> 1;
  assign w_gnt_multi = |(i_gnt & w_gnt_hi);
  assign w_ld_bad    = ~|i_load_ptr | (|(i_load_ptr & w_ld_hi));

  always_comb begin
    w_nxt_ptr = r_ptr;
    w_nxt_err = 1'b0;
    if (i_load) begin
      if (w_ld_bad) w_nxt_err = 1'b1;
      else          w_nxt_ptr = i_load_ptr;
    end else if (i_update && |i_gnt) begin
      if (w_gnt_multi) w_nxt_err = 1'b1;
      else             w_nxt_ptr = w_adv;
    end
  end

  logic r_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_err <= 1'b0;
    else          r_err <= w_nxt_err;
  end
  assign o_err = r_err;
`else
  always_comb begin
    w_nxt_ptr = r_ptr;
    w_nxt_err = 1'b0;
    if (i_load)                   w_nxt_ptr = i_load_ptr;
    else if (i_update && |i_gnt)  w_nxt_ptr = w_adv;
  end
  assign o_err = w_nxt_err & 1'b0;
`endif

  // Mask is registered alongside the pointer so the two never disagree.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr  <= RST_PTR;
      r_mask <= RST_MASK;
    end else begin
      r_ptr  <= w_nxt_ptr;
      r_mask <= pfx_or(w_nxt_ptr);
    end
  end

  assign o_ptr  = r_ptr;
  assign o_mask = r_mask;
endmodule

module c_rr_therm_mask #(
  parameter int width     = 8,
  parameter int num_chan  = 1,
  parameter int reset_idx = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [num_chan-1:0]       i_update,
  input  logic [num_chan*width-1:0] i_gnt,
  input  logic [num_chan-1:0]       i_load,
  input  logic [num_chan*width-1:0] i_load_ptr,
  output logic [num_chan*width-1:0] o_ptr,
  output logic [num_chan*width-1:0] o_mask,
  output logic [num_chan-1:0]       o_err
);
  logic [num_chan-1:0][width-1:0] w_gnt, w_load_ptr, w_ptr, w_mask;

  assign w_gnt      = i_gnt;
  assign w_load_ptr = i_load_ptr;
  assign o_ptr      = w_ptr;
  assign o_mask     = w_mask;

  for (genvar c = 0; c < num_chan; c++) begin : g_chan
    c_rr_therm_mask_chan #(
      .width     (width),
      .reset_idx (reset_idx)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_update   (i_update[c]),
      .i_gnt      (w_gnt[c]),
      .i_load     (i_load[c]),
      .i_load_ptr (w_load_ptr[c]),
      .o_ptr      (w_ptr[c]),
      .o_mask     (w_mask[c]),
      .o_err      (o_err[c])
    );
  end
endmodule
